// File: rtl/id_ex_stage_if.sv
`timescale 1ns/1ps
// Decode-to-execute pipeline bus: decoded instruction and control in,
// registered EX-stage copy, upstream stall and bubble counter out.
interface id_ex_stage_if;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [4:0]  id_rd, id_rs1, id_rs2;
    logic [2:0]  id_func3;
    logic [31:0] id_imm, id_rs1_data, id_rs2_data;
    logic        id_alu_src, id_mem_write, id_mem_read, id_wb_reg_file, id_memtoreg;
    logic        id_branch, id_jal, id_jalr, id_auipc, id_lui;
    logic [2:0]  id_mem_load_type;
    logic [1:0]  id_mem_store_type;
    logic [3:0]  id_alu_ctrl;
    logic        ex_flush, ex_hold;

    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [4:0]  ex_rd, ex_rs1, ex_rs2;
    logic [2:0]  ex_func3;
    logic [31:0] ex_imm, ex_rs1_data, ex_rs2_data;
    logic        ex_alu_src, ex_mem_write, ex_mem_read, ex_wb_reg_file, ex_memtoreg;
    logic        ex_branch, ex_jal, ex_jalr, ex_auipc, ex_lui;
    logic [2:0]  ex_mem_load_type;
    logic [1:0]  ex_mem_store_type;
    logic [3:0]  ex_alu_ctrl;
    logic        id_stall;
    logic [15:0] bubble_count;

    modport master (
        output id_valid, id_pc, id_rd, id_rs1, id_rs2, id_func3, id_imm, id_rs1_data,
               id_rs2_data, id_alu_src, id_mem_write, id_mem_read, id_wb_reg_file,
               id_memtoreg, id_branch, id_jal, id_jalr, id_auipc, id_lui,
               id_mem_load_type, id_mem_store_type, id_alu_ctrl, ex_flush, ex_hold,
        input  ex_valid, ex_pc, ex_rd, ex_rs1, ex_rs2, ex_func3, ex_imm, ex_rs1_data,
               ex_rs2_data, ex_alu_src, ex_mem_write, ex_mem_read, ex_wb_reg_file,
               ex_memtoreg, ex_branch, ex_jal, ex_jalr, ex_auipc, ex_lui,
               ex_mem_load_type, ex_mem_store_type, ex_alu_ctrl, id_stall, bubble_count
    );

    modport slave (
        input  id_valid, id_pc, id_rd, id_rs1, id_rs2, id_func3, id_imm, id_rs1_data,
               id_rs2_data, id_alu_src, id_mem_write, id_mem_read, id_wb_reg_file,
               id_memtoreg, id_branch, id_jal, id_jalr, id_auipc, id_lui,
               id_mem_load_type, id_mem_store_type, id_alu_ctrl, ex_flush, ex_hold,
        output ex_valid, ex_pc, ex_rd, ex_rs1, ex_rs2, ex_func3, ex_imm, ex_rs1_data,
               ex_rs2_data, ex_alu_src, ex_mem_write, ex_mem_read, ex_wb_reg_file,
               ex_memtoreg, ex_branch, ex_jal, ex_jalr, ex_auipc, ex_lui,
               ex_mem_load_type, ex_mem_store_type, ex_alu_ctrl, id_stall, bubble_count
    );
endinterface

// File: rtl/id_ex_stage.sv
`timescale 1ns/1ps
// ID/EX pipeline register with load-use hazard detection, bubble insertion,
// flush/hold control and a saturating count of inserted load-use bubbles.
module id_ex_stage (
    input  logic         clk,
    input  logic         rst,
    id_ex_stage_if.slave bus
);
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  func3;
        logic [31:0] imm;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic        alu_src;
        logic        mem_write;
        logic        mem_read;
        logic        wb_reg_file;
        logic        memtoreg;
        logic        branch;
        logic        jal;
        logic        jalr;
        logic        auipc;
        logic        lui;
        logic [2:0]  mem_load_type;
        logic [1:0]  mem_store_type;
        logic [3:0]  alu_ctrl;
    } ex_regs_t;

    ex_regs_t    id_load;
    ex_regs_t    ex_d, ex_q;
    logic [15:0] bubble_count_d, bubble_count_q;
    logic        use_rs1, use_rs2, hz;

    always_comb begin
        id_load.valid          = bus.id_valid;
        id_load.pc             = bus.id_pc;
        id_load.rd             = bus.id_rd;
        id_load.rs1            = bus.id_rs1;
        id_load.rs2            = bus.id_rs2;
        id_load.func3          = bus.id_func3;
        id_load.imm            = bus.id_imm;
        id_load.rs1_data       = bus.id_rs1_data;
        id_load.rs2_data       = bus.id_rs2_data;
        id_load.alu_src        = bus.id_alu_src;
        id_load.mem_write      = bus.id_mem_write;
        id_load.mem_read       = bus.id_mem_read;
        id_load.wb_reg_file    = bus.id_wb_reg_file;
        id_load.memtoreg       = bus.id_memtoreg;
        id_load.branch         = bus.id_branch;
        id_load.jal            = bus.id_jal;
        id_load.jalr           = bus.id_jalr;
        id_load.auipc          = bus.id_auipc;
        id_load.lui            = bus.id_lui;
        id_load.mem_load_type  = bus.id_mem_load_type;
        id_load.mem_store_type = bus.id_mem_store_type;
        id_load.alu_ctrl       = bus.id_alu_ctrl;
        // An empty slot must not cause any architectural side effect downstream.
        if (!bus.id_valid) begin
            id_load.mem_write   = 1'b0;
            id_load.mem_read    = 1'b0;
            id_load.wb_reg_file = 1'b0;
            id_load.branch      = 1'b0;
            id_load.jal         = 1'b0;
            id_load.jalr        = 1'b0;
        end
    end

    always_comb begin
        use_rs1 = ~(bus.id_jal | bus.id_lui | bus.id_auipc);
        use_rs2 = ~bus.id_alu_src | bus.id_mem_write;
        hz      = ex_q.valid & ex_q.mem_read & (ex_q.rd != 5'd0) & bus.id_valid &
                  ((use_rs1 & (bus.id_rs1 == ex_q.rd)) | (use_rs2 & (bus.id_rs2 == ex_q.rd)));
    end

    assign bus.id_stall = (hz & ~bus.ex_flush) | bus.ex_hold;

    always_comb begin
        ex_d           = ex_q;
        bubble_count_d = bubble_count_q;
        if (bus.ex_flush) begin
            ex_d = '0;
        end else if (bus.ex_hold) begin
            ex_d = ex_q;
        end else if (hz) begin
            ex_d = '0;
            if (bubble_count_q != 16'hFFFF) begin
                bubble_count_d = bubble_count_q + 16'd1;
            end
        end else begin
            ex_d = id_load;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_q           <= '0;
            bubble_count_q <= '0;
        end else begin
            ex_q           <= ex_d;
            bubble_count_q <= bubble_count_d;
        end
    end

    assign bus.ex_valid          = ex_q.valid;
    assign bus.ex_pc             = ex_q.pc;
    assign bus.ex_rd             = ex_q.rd;
    assign bus.ex_rs1            = ex_q.rs1;
    assign bus.ex_rs2            = ex_q.rs2;
    assign bus.ex_func3          = ex_q.func3;
    assign bus.ex_imm            = ex_q.imm;
    assign bus.ex_rs1_data       = ex_q.rs1_data;
    assign bus.ex_rs2_data       = ex_q.rs2_data;
    assign bus.ex_alu_src        = ex_q.alu_src;
    assign bus.ex_mem_write      = ex_q.mem_write;
    assign bus.ex_mem_read       = ex_q.mem_read;
    assign bus.ex_wb_reg_file    = ex_q.wb_reg_file;
    assign bus.ex_memtoreg       = ex_q.memtoreg;
    assign bus.ex_branch         = ex_q.branch;
    assign bus.ex_jal            = ex_q.jal;
    assign bus.ex_jalr           = ex_q.jalr;
    assign bus.ex_auipc          = ex_q.auipc;
    assign bus.ex_lui            = ex_q.lui;
    assign bus.ex_mem_load_type  = ex_q.mem_load_type;
    assign bus.ex_mem_store_type = ex_q.mem_store_type;
    assign bus.ex_alu_ctrl       = ex_q.alu_ctrl;
    assign bus.bubble_count      = bubble_count_q;
endmodule
